// File: rtl/jump_addr_if.sv
// Fetch/decode-side bundle of the jump address unit: decode-stage inputs, PC and
// return-stack status outputs.
interface jump_addr_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8,
    parameter int DEPTH   = 4
);
    localparam int SD_W = $clog2(DEPTH + 1);

    logic [INSTR_W-1:0] instr;
    logic               instr_vld;
    logic [1:0]         jmp_mode;
    logic               stall;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  dec_pc;
    logic [ADDR_W-1:0]  jmp_addr;
    logic               jmp_taken;
    logic               flush;
    logic [SD_W-1:0]    stk_depth;
    logic               stk_ovf;
    logic               stk_udf;

    modport master (
        output instr, instr_vld, jmp_mode, stall,
        input  pc, dec_pc, jmp_addr, jmp_taken, flush, stk_depth, stk_ovf, stk_udf
    );

    modport slave (
        input  instr, instr_vld, jmp_mode, stall,
        output pc, dec_pc, jmp_addr, jmp_taken, flush, stk_depth, stk_ovf, stk_udf
    );
endinterface

// File: rtl/jump_addr_unit.sv
// Fetch PC owner: decodes jump-class instructions (abs/rel/call/ret), keeps the
// return-address stack and flushes the wrong-path fetch for one cycle.
module jump_addr_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 8,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    jump_addr_if.slave  bus
);
    localparam int IMM_W = INSTR_W - 2;
    localparam int SD_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] MODE_ABS  = 2'b00;
    localparam logic [1:0] MODE_REL  = 2'b01;
    localparam logic [1:0] MODE_CALL = 2'b10;
    localparam logic [1:0] MODE_RET  = 2'b11;

    logic [ADDR_W-1:0]       pc_q;
    logic [ADDR_W-1:0]       dec_pc_q;
    logic                    flush_q;
    logic [ADDR_W-1:0]       stk [DEPTH];
    logic [SD_W-1:0]         depth_q;
    logic                    ovf_q;
    logic                    udf_q;

    logic [1:0]              opcode;
    logic signed [IMM_W-1:0] imm;
    logic [ADDR_W-1:0]       simm;
    logic                    eff;
    logic                    stk_empty;
    logic                    stk_full;
    logic [IDX_W-1:0]        top_idx;
    logic [IDX_W-1:0]        push_idx;
    logic [ADDR_W-1:0]       stk_top;

    logic                    taken;
    logic [ADDR_W-1:0]       target;
    logic                    do_push;
    logic                    do_pop;
    logic                    set_ovf;
    logic                    set_udf;

    assign opcode    = bus.instr[INSTR_W-1 -: 2];
    assign imm       = bus.instr[IMM_W-1:0];
    assign simm      = ADDR_W'(imm);
    assign eff       = bus.instr_vld & ~flush_q & ~bus.stall & (opcode == 2'b11);
    assign stk_empty = (depth_q == '0);
    assign stk_full  = (depth_q == SD_W'(DEPTH));
    assign top_idx   = IDX_W'(depth_q - SD_W'(1));
    assign push_idx  = IDX_W'(depth_q);
    assign stk_top   = stk_empty ? '0 : stk[top_idx];

    always_comb begin
        taken   = 1'b0;
        target  = '0;
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_ovf = 1'b0;
        set_udf = 1'b0;
        if (eff) begin
            case (bus.jmp_mode)
                MODE_ABS: begin
                    taken  = 1'b1;
                    target = simm;
                end
                MODE_REL: begin
                    taken  = 1'b1;
                    target = dec_pc_q + simm;
                end
                MODE_CALL: begin
                    // The jump always happens; only the push is lost on overflow.
                    taken   = 1'b1;
                    target  = simm;
                    do_push = ~stk_full;
                    set_ovf = stk_full;
                end
                MODE_RET: begin
                    taken   = ~stk_empty;
                    target  = stk_top;
                    do_pop  = ~stk_empty;
                    set_udf = stk_empty;
                end
                default: begin
                    taken = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            dec_pc_q <= RESET_PC;
            flush_q  <= 1'b0;
            depth_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stk[i] <= '0;
            end
        end else if (!bus.stall) begin
            dec_pc_q <= pc_q;
            pc_q     <= taken ? target : pc_q + ADDR_W'(1);
            flush_q  <= taken;
            if (do_push) begin
                stk[push_idx] <= dec_pc_q + ADDR_W'(1);
                depth_q       <= depth_q + SD_W'(1);
            end else if (do_pop) begin
                depth_q <= depth_q - SD_W'(1);
            end
            if (set_ovf) ovf_q <= 1'b1;
            if (set_udf) udf_q <= 1'b1;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.dec_pc    = dec_pc_q;
    assign bus.jmp_addr  = taken ? target : '0;
    assign bus.jmp_taken = taken;
    assign bus.flush     = flush_q;
    assign bus.stk_depth = depth_q;
    assign bus.stk_ovf   = ovf_q;
    assign bus.stk_udf   = udf_q;
endmodule

// File: tb/tb_jump_addr_unit.sv
// Bench for jump_addr_unit: directed scenarios then random instructions, all checked
// against a queue-based reference model of the fetch/jump rules.
module tb_jump_addr_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    int m_pc, m_dec;
    bit m_flush, m_ovf, m_udf;
    int m_stk[$];

    jump_addr_if #(.ADDR_W(8), .INSTR_W(8), .DEPTH(4)) bus ();

    jump_addr_unit #(.ADDR_W(8), .INSTR_W(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_dec = 0; m_flush = 0; m_ovf = 0; m_udf = 0;
        m_stk.delete();
    endtask

    task automatic check_regs();
        chk("pc", 32'(bus.pc), 32'(m_pc));
        chk("dec_pc", 32'(bus.dec_pc), 32'(m_dec));
        chk("flush", 32'(bus.flush), 32'(m_flush));
        chk("stk_depth", 32'(bus.stk_depth), 32'(m_stk.size()));
        chk("stk_ovf", 32'(bus.stk_ovf), 32'(m_ovf));
        chk("stk_udf", 32'(bus.stk_udf), 32'(m_udf));
    endtask

    // One cycle: drive, check the combinational jump result, clock, check state.
    task automatic step(input bit v, input bit [7:0] ins, input bit [1:0] md, input bit st);
        int imm, addr;
        bit eff, tk;
        bus.instr = ins; bus.instr_vld = v; bus.jmp_mode = md; bus.stall = st;
        #1;
        imm = int'(ins) & 63;
        if (imm >= 32) imm -= 64;
        eff = v && !m_flush && !st && (ins[7:6] == 2'b11);
        tk = 0; addr = 0;
        if (eff) begin
            case (md)
                2'd0: begin tk = 1; addr = imm & 255; end
                2'd1: begin tk = 1; addr = (m_dec + imm) & 255; end
                2'd2: begin
                    tk = 1; addr = imm & 255;
                    if (m_stk.size() < 4) m_stk.push_back((m_dec + 1) & 255);
                    else m_ovf = 1;
                end
                default: begin
                    if (m_stk.size() > 0) begin tk = 1; addr = m_stk.pop_back(); end
                    else m_udf = 1;
                end
            endcase
        end
        chk("jmp_taken", 32'(bus.jmp_taken), 32'(tk));
        chk("jmp_addr", 32'(bus.jmp_addr), 32'(addr));
        @(posedge clk);
        #1;
        if (!st) begin
            m_dec = m_pc;
            m_pc = tk ? addr : (m_pc + 1) & 255;
            m_flush = tk;
        end
        check_regs();
    endtask

    task automatic nop();
        step(0, 8'h00, 2'b00, 0);
    endtask

    initial begin
        bus.instr = '0; bus.instr_vld = 0; bus.jmp_mode = '0; bus.stall = 0;
        model_reset();
        #12;
        chk("rst_pc", 32'(bus.pc), 32'h0);
        chk("rst_flush", 32'(bus.flush), 32'h0);
        chk("rst_depth", 32'(bus.stk_depth), 32'h0);
        rst_n = 1'b1;

        // free-running fetch
        for (int i = 0; i < 5; i++) nop();
        chk("seq_pc5", 32'(bus.pc), 32'h05);

        // absolute jump to FE, call during flush ignored, wrap FF -> 00
        step(1, 8'hFE, 2'b00, 0);
        chk("abs_pc", 32'(bus.pc), 32'hFE);
        chk("abs_flush", 32'(bus.flush), 32'h1);
        step(1, 8'hC3, 2'b10, 0);
        chk("abs_pc_next", 32'(bus.pc), 32'hFF);
        chk("flush_ignored_call", 32'(bus.stk_depth), 32'h0);
        nop();
        chk("wrap_pc", 32'(bus.pc), 32'h00);

        // relative jumps
        step(1, 8'hD0, 2'b00, 0);
        nop();
        chk("rel_dec_pc", 32'(bus.dec_pc), 32'h10);
        step(1, 8'hFE, 2'b01, 0);
        chk("rel_pc", 32'(bus.pc), 32'h0E);
        nop();
        step(1, 8'hC2, 2'b00, 0);
        nop();
        step(1, 8'hF8, 2'b01, 0);
        chk("rel_wrap_pc", 32'(bus.pc), 32'hFA);

        // call at 20 and matching return
        nop();
        step(1, 8'hDF, 2'b00, 0);
        nop();
        nop();
        step(1, 8'hC5, 2'b10, 0);
        chk("call_pc", 32'(bus.pc), 32'h05);
        chk("call_depth", 32'(bus.stk_depth), 32'h1);
        nop();
        nop();
        step(1, 8'hC0, 2'b11, 0);
        chk("ret_pc", 32'(bus.pc), 32'h21);
        chk("ret_depth", 32'(bus.stk_depth), 32'h0);

        // overflow then full unwind and underflow
        nop();
        for (int i = 0; i < 5; i++) begin
            step(1, 8'hC8 + 8'(i), 2'b10, 0);
            nop();
        end
        chk("ovf_flag", 32'(bus.stk_ovf), 32'h1);
        chk("ovf_depth", 32'(bus.stk_depth), 32'h4);
        for (int i = 0; i < 4; i++) begin
            step(1, 8'hC0, 2'b11, 0);
            nop();
        end
        step(1, 8'hC0, 2'b11, 0);
        chk("udf_flag", 32'(bus.stk_udf), 32'h1);
        chk("udf_no_flush", 32'(bus.flush), 32'h0);

        // stall freezes, release takes the jump, reset during flush
        step(1, 8'hC9, 2'b10, 0);
        nop();
        step(1, 8'hC7, 2'b00, 1);
        step(1, 8'hC7, 2'b00, 0);
        chk("stall_release_pc", 32'(bus.pc), 32'h07);
        chk("stall_release_flush", 32'(bus.flush), 32'h1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_pc", 32'(bus.pc), 32'h0);
        chk("async_rst_flush", 32'(bus.flush), 32'h0);
        chk("async_rst_depth", 32'(bus.stk_depth), 32'h0);
        chk("async_rst_ovf", 32'(bus.stk_ovf), 32'h0);
        bus.instr_vld = 0; bus.stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        nop();
        chk("post_rst_pc", 32'(bus.pc), 32'h01);

        // random instruction stream
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom),
                 $urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
